spi_ctrl_tx: RTL and testbench

//  SPI controller (initiator) transmitter, mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_ctrl_tx_pkg.sv | 28 ++
 rtl/spi_ctrl_tx_if.sv | 16 +
 rtl/spi_ctrl_tx_clk_div.sv | 31 +++
 rtl/spi_ctrl_tx.sv | 127 ++++++++++++
 tb/tb_spi_ctrl_tx.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_tx_pkg.sv
// Shared definitions for the SPI controller transmitter: FSM state encoding,
// default frame parameters, the serial pin bundle and a counter-width helper.
package spi_ctrl_tx_pkg;

    localparam int unsigned SPI_DATA_W  = 8;
    localparam int unsigned SPI_CLK_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    typedef struct packed {
        logic sclk;
        logic mosi;
        logic cs;
    } spi_pins_t;

    // Width of a counter covering 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_ctrl_tx_if.sv
// Host-side request/status handshake of the SPI controller transmitter.
interface spi_ctrl_tx_if
    import spi_ctrl_tx_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
) ();

    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;

    modport master (output tx_start, output tx_data, input busy, input done);
    modport slave  (input tx_start, input tx_data, output busy, output done);

endinterface

// File: rtl/spi_ctrl_tx_clk_div.sv
// Phase timer: counts CLK_DIV clk cycles and flags the last cycle of a phase.
module spi_ctrl_tx_clk_div
    import spi_ctrl_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase_end_c
);

    localparam int unsigned    CNT_W = cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign phase_end_c = (cnt_q == LAST);

    // Wrapping at phase end restarts the count for the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || phase_end_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_ctrl_tx.sv
// SPI mode-0 controller transmitter, MSB first: one DATA_W-bit word per
// accepted request, with sclk/cs generated from clk via a phase timer.
module spi_ctrl_tx
    import spi_ctrl_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = SPI_DATA_W,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_ctrl_tx_if.slave  host,
    output logic          sclk,
    output logic          mosi,
    output logic          cs
);

    localparam int unsigned      BIT_W    = cnt_w(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam spi_pins_t        PINS_IDLE = '{sclk: 1'b0, mosi: 1'b0, cs: 1'b1};

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    spi_pins_t         pins_q, pins_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              phase_end_c;

    spi_ctrl_tx_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (state_q == ST_IDLE),
        .phase_end_c (phase_end_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pins_q    <= PINS_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            pins_q    <= pins_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        pins_d    = pins_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (host.tx_start) begin
                    shreg_d     = host.tx_data;
                    pins_d.mosi = host.tx_data[DATA_W-1];
                    pins_d.cs   = 1'b0;
                    busy_d      = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_end_c) begin
                    pins_d.sclk = 1'b1;
                    state_d     = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_end_c) begin
                    pins_d.sclk = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Rotate rather than shift; bits past the frame are never sent
                        shreg_d     = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
                        pins_d.mosi = shreg_q[DATA_W-2];
                        bit_cnt_d   = bit_cnt_q + BIT_W'(1);
                        state_d     = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (phase_end_c) begin
                    pins_d.sclk = 1'b1;
                    state_d     = ST_HIGH;
                end
            end
            ST_HOLD: begin
                if (phase_end_c) begin
                    pins_d.cs   = 1'b1;
                    pins_d.mosi = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (phase_end_c) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sclk      = pins_q.sclk;
    assign mosi      = pins_q.mosi;
    assign cs        = pins_q.cs;
    assign host.busy = busy_q;
    assign host.done = done_q;

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// Scoreboard bench for spi_ctrl_tx: two instances (CLK_DIV 4 and 1) with a
// cycle-stamped peripheral monitor checking timing, bits, done and busy.
module tb_spi_ctrl_tx;
    import spi_ctrl_tx_pkg::*;

    localparam int DW    = 8;
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;
    localparam int FRAME = 2 * DW + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ctrl_tx_if #(.DATA_W(DW)) if_a ();
    spi_ctrl_tx_if #(.DATA_W(DW)) if_b ();

    wire [1:0] sclk_w;
    wire [1:0] mosi_w;
    wire [1:0] cs_w;
    wire [1:0] busy_w = {if_b.busy, if_a.busy};
    wire [1:0] done_w = {if_b.done, if_a.done};

    spi_ctrl_tx #(.DATA_W(DW), .CLK_DIV(DIV_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (if_a.slave),
        .sclk  (sclk_w[0]),
        .mosi  (mosi_w[0]),
        .cs    (cs_w[0])
    );

    spi_ctrl_tx #(.DATA_W(DW), .CLK_DIV(DIV_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (if_b.slave),
        .sclk  (sclk_w[1]),
        .mosi  (mosi_w[1]),
        .cs    (cs_w[1])
    );

    typedef struct {
        int         d;
        logic [7:0] data;
        int         acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   abort_rises = -1;
    int   frames_seen = 0;
    int   frames_sent = 0;
    int   next_ok = 0;
    int   last_acc = 0;

    function automatic int div_of(input int d);
        return (d == 0) ? DIV_A : DIV_B;
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int d, input logic st, input logic [7:0] dat);
        if (d == 0) begin
            if_a.tx_start = st;
            if_a.tx_data  = dat;
        end else begin
            if_b.tx_start = st;
            if_b.tx_data  = dat;
        end
    endtask

    // Request that must be ignored: lands on clk edge number edge_at
    task automatic pulse(input int d, input int edge_at);
        while (cyc + 1 < edge_at) @(negedge clk);
        drive(d, 1'b1, 8'($urandom));
        @(negedge clk);
        drive(d, 1'b0, 8'($urandom));
    endtask

    task automatic send(input int d, input logic [7:0] data, input int p1, input int p2);
        int div = div_of(d);
        int acc;
        @(negedge clk);
        while (cyc + 1 < next_ok) @(negedge clk);
        drive(d, 1'b1, data);
        acc = cyc + 1;
        sb_q.push_back('{d: d, data: data, acc: acc});
        frames_sent++;
        last_acc = acc;
        next_ok  = acc + FRAME * div + 1;
        @(negedge clk);
        drive(d, 1'b0, 8'($urandom));
        if (p1 > 0) pulse(d, acc + p1);
        if (p2 > 0) pulse(d, acc + p2);
    endtask

    task automatic send_held(input int d, input logic [7:0] a, input logic [7:0] b);
        int div = div_of(d);
        int acc1;
        int acc2;
        @(negedge clk);
        while (cyc + 1 < next_ok) @(negedge clk);
        drive(d, 1'b1, a);
        acc1 = cyc + 1;
        acc2 = acc1 + FRAME * div + 1;
        sb_q.push_back('{d: d, data: a, acc: acc1});
        sb_q.push_back('{d: d, data: b, acc: acc2});
        frames_sent += 2;
        @(negedge clk);
        drive(d, 1'b1, b);
        while (cyc < acc2) @(negedge clk);
        drive(d, 1'b0, 8'($urandom));
        last_acc = acc2;
        next_ok  = acc2 + FRAME * div + 1;
    endtask

    task automatic send_random(input int d, input int n);
        int div = div_of(d);
        int p1;
        int p2;
        for (int i = 0; i < n; i++) begin
            next_ok += int'($urandom_range(0, 5));
            p1 = 0;
            p2 = 0;
            if ($urandom_range(0, 1) == 1) begin
                p1 = int'($urandom_range(2, 9 * div));
                p2 = int'($urandom_range(9 * div + 1, FRAME * div));
            end
            send(d, 8'($urandom), p1, p2);
        end
    endtask

    // Peripheral model: samples every clk edge, captures mosi on sclk rise while cs=0
    task automatic monitor(input int d);
        int         div = div_of(d);
        bit         in_frame = 1'b0;
        bit         wait_busy = 1'b0;
        int         nrise = 0;
        int         e;
        logic [7:0] word = 8'h00;
        exp_t       cur = '{d: 0, data: 8'h00, acc: 0};
        logic       p_sclk = 1'b0, p_mosi = 1'b0, p_cs = 1'b1, p_busy = 1'b0;
        logic       s, m, c, b, dn;
        forever begin
            @(posedge clk);
            #1;
            s  = sclk_w[d];
            m  = mosi_w[d];
            c  = cs_w[d];
            b  = busy_w[d];
            dn = done_w[d];
            if (!rst_n) begin
                if (in_frame) abort_rises = nrise;
                in_frame  = 1'b0;
                wait_busy = 1'b0;
                p_sclk = 1'b0;
                p_mosi = 1'b0;
                p_cs   = 1'b1;
                p_busy = 1'b0;
                continue;
            end
            e = cyc;
            if (c) check(s == 1'b0, "sclk_low_while_cs_high", int'(s), 0);
            if (p_cs && !c) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_frame", e, 0);
                end else begin
                    cur = sb_q.pop_front();
                    check(cur.d == d, "frame_on_wrong_dut", d, cur.d);
                    check(e == cur.acc, "accept_edge", e, cur.acc);
                    check(b == 1'b1, "busy_on_accept", int'(b), 1);
                end
                in_frame = 1'b1;
                nrise    = 0;
                word     = 8'h00;
            end
            if (!p_sclk && s && !c && in_frame) begin
                check(m == p_mosi, "mosi_stable_at_rise", int'(m), int'(p_mosi));
                check(e == cur.acc + div + 2 * div * nrise, "sclk_rise_time", e,
                      cur.acc + div + 2 * div * nrise);
                if (nrise < DW) check(m == cur.data[DW-1-nrise], "mosi_bit", int'(m),
                                      int'(cur.data[DW-1-nrise]));
                word = {word[6:0], m};
                nrise++;
            end
            if (!p_cs && c && in_frame) begin
                check(nrise == DW, "sclk_edge_count", nrise, DW);
                check(word == cur.data, "captured_word", int'(word), int'(cur.data));
                check(dn == 1'b1, "done_pulse", int'(dn), 1);
                check(e == cur.acc + (2 * DW + 1) * div, "done_time", e,
                      cur.acc + (2 * DW + 1) * div);
                check(m == 1'b0, "mosi_idle_after_frame", int'(m), 0);
                frames_seen++;
                in_frame  = 1'b0;
                wait_busy = 1'b1;
            end else begin
                check(dn == 1'b0, "no_spurious_done", int'(dn), 0);
            end
            if (p_busy && !b) begin
                check(wait_busy, "busy_fall_expected", int'(b), 1);
                if (wait_busy) check(e == cur.acc + FRAME * div, "busy_fall_time", e,
                                     cur.acc + FRAME * div);
                wait_busy = 1'b0;
            end
            p_sclk = s;
            p_mosi = m;
            p_cs   = c;
            p_busy = b;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected end", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check(cs_w[d] == 1'b1, "reset_cs", int'(cs_w[d]), 1);
            check(sclk_w[d] == 1'b0, "reset_sclk", int'(sclk_w[d]), 0);
            check(mosi_w[d] == 1'b0, "reset_mosi", int'(mosi_w[d]), 0);
            check(busy_w[d] == 1'b0, "reset_busy", int'(busy_w[d]), 0);
            check(done_w[d] == 1'b0, "reset_done", int'(done_w[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        send(0, 8'hA5, 0, 0);
        send(0, 8'h5A, 10, 40);
        send_random(0, 8);
        send_held(0, 8'h3C, 8'hC3);

        // Abort a frame after its third sclk rise, between clk edges
        send(0, 8'hFF, 0, 0);
        frames_sent--;
        while (cyc < last_acc + 5 * DIV_A + 1) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check(cs_w[0] == 1'b1, "async_reset_cs", int'(cs_w[0]), 1);
        check(sclk_w[0] == 1'b0, "async_reset_sclk", int'(sclk_w[0]), 0);
        check(mosi_w[0] == 1'b0, "async_reset_mosi", int'(mosi_w[0]), 0);
        check(busy_w[0] == 1'b0, "async_reset_busy", int'(busy_w[0]), 0);
        check(done_w[0] == 1'b0, "async_reset_done", int'(done_w[0]), 0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        next_ok = 0;
        check(abort_rises == 3, "aborted_frame_rises", abort_rises, 3);
        send(0, 8'h81, 0, 0);

        send(1, 8'h00, 0, 0);
        send(1, 8'hFF, 0, 0);
        send_random(1, 6);
        send_held(1, 8'($urandom), 8'($urandom));

        while (cyc < next_ok + 4) @(negedge clk);
        check(sb_q.size() == 0, "frames_outstanding", sb_q.size(), 0);
        check(frames_seen == frames_sent, "frames_completed", frames_seen, frames_sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
